adc_capture_buffer: RTL and testbench



---
 rtl/adc_cap_pkg.sv | 12 +
 rtl/sample_ram.sv | 28 ++
 rtl/adc_capture_buffer.sv | 136 +++++++++++++
 tb/tb_adc_capture_buffer.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/adc_cap_pkg.sv
// Shared types and defaults for the ADC capture buffer.
package adc_cap_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 12;

  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_TRIG = 2'd1,
    POST      = 2'd2,
    DONE      = 2'd3
  } cap_state_t;
endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (old data on collision).
module sample_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered ADC capture into a circular buffer, frozen for the renderer until Frame_Start.
// Optional forced trigger after AUTO_TIMEOUT samples when ADC_CAP_AUTO_TRIG_EN is defined.
module adc_capture_buffer
  import adc_cap_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int PRE_TRIG     = 512,
  parameter int AUTO_TIMEOUT = 65535
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] Sample_In,
  input  logic              Sample_Valid,
  input  logic [DATA_W-1:0] Trig_Level,
  input  logic              Frame_Start,
  input  logic [ADDR_W-1:0] Rd_Addr,
  output logic [DATA_W-1:0] Rd_Data,
  output logic [ADDR_W-1:0] Start_Offset,
  output logic [ADDR_W-1:0] Trig_Addr,
  output logic              Frozen
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PRE_A   = ADDR_W'(PRE_TRIG);
  localparam logic [ADDR_W-1:0] POST_LD = ADDR_W'(DEPTH - PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  if (PRE_TRIG < 1 || PRE_TRIG > DEPTH - 2 || AUTO_TIMEOUT < 1) begin : g_bad_param
    $error("adc_capture_buffer: illegal PRE_TRIG or AUTO_TIMEOUT");
  end

  cap_state_t        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_fill_cnt, w_fill_nxt;
  logic [ADDR_W-1:0] r_post_cnt, w_post_nxt;
  logic [ADDR_W-1:0] r_trig_addr, w_trig_nxt;
  logic [ADDR_W-1:0] r_start_off, w_start_nxt;
  logic              r_frozen, w_frozen_nxt;
  logic [DATA_W-1:0] r_prev;
  logic              w_we, w_cross, w_timeout;

  assign w_we    = Sample_Valid && (r_state != DONE);
  assign w_cross = (r_prev < Trig_Level) && (Sample_In >= Trig_Level);

`ifdef ADC_CAP_AUTO_TRIG_EN
  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  // Held at zero outside WAIT_TRIG, so it restarts on every entry.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                   r_to_cnt <= '0;
    else if (r_state != WAIT_TRIG) r_to_cnt <= '0;
    else if (Sample_Valid)        r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  assign w_timeout = (r_to_cnt == TO_W'(AUTO_TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_fill_nxt   = r_fill_cnt;
    w_post_nxt   = r_post_cnt;
    w_trig_nxt   = r_trig_addr;
    w_start_nxt  = r_start_off;
    w_frozen_nxt = r_frozen;
    case (r_state)
      FILL: if (Sample_Valid) begin
        w_fill_nxt = r_fill_cnt + ONE_A;
        if (r_fill_cnt == PRE_A - ONE_A) w_state_nxt = WAIT_TRIG;
      end
      WAIT_TRIG: if (Sample_Valid && (w_cross || w_timeout)) begin
        w_trig_nxt  = r_wr_ptr;
        w_start_nxt = r_wr_ptr - PRE_A;
        w_post_nxt  = POST_LD;
        w_state_nxt = POST;
      end
      // Count reaching zero after this decrement marks the final window sample.
      POST: if (Sample_Valid) begin
        w_post_nxt = r_post_cnt - ONE_A;
        if (r_post_cnt == ONE_A) begin
          w_state_nxt  = DONE;
          w_frozen_nxt = 1'b1;
        end
      end
      DONE: if (Frame_Start) begin
        w_frozen_nxt = 1'b0;
        w_fill_nxt   = '0;
        w_state_nxt  = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= FILL;
      r_wr_ptr    <= '0;
      r_fill_cnt  <= '0;
      r_post_cnt  <= '0;
      r_trig_addr <= '0;
      r_start_off <= '0;
      r_frozen    <= 1'b0;
      r_prev      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fill_cnt  <= w_fill_nxt;
      r_post_cnt  <= w_post_nxt;
      r_trig_addr <= w_trig_nxt;
      r_start_off <= w_start_nxt;
      r_frozen    <= w_frozen_nxt;
      if (w_we) begin
        r_wr_ptr <= r_wr_ptr + ONE_A;
        r_prev   <= Sample_In;
      end
    end
  end

  sample_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .i_clk  (Clk),
    .i_rst_n(Rst_n),
    .i_we   (w_we),
    .i_waddr(r_wr_ptr),
    .i_wdata(Sample_In),
    .i_raddr(Rd_Addr),
    .o_rdata(Rd_Data)
  );

  assign Trig_Addr    = r_trig_addr;
  assign Start_Offset = r_start_off;
  assign Frozen       = r_frozen;
endmodule

// File: tb/tb_adc_capture_buffer.sv
// Directed bench for adc_capture_buffer (DEPTH 4096, PRE_TRIG 512, AUTO_TIMEOUT 16).
module tb_adc_capture_buffer;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [7:0]  Sample_In = '0;
  logic        Sample_Valid = 1'b0;
  logic [7:0]  Trig_Level = '0;
  logic        Frame_Start = 1'b0;
  logic [11:0] Rd_Addr = '0;
  logic [7:0]  Rd_Data;
  logic [11:0] Start_Offset, Trig_Addr;
  logic        Frozen;
  int n_chk = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  adc_capture_buffer #(
    .DATA_W(8), .ADDR_W(12), .PRE_TRIG(512), .AUTO_TIMEOUT(16)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Sample_In(Sample_In), .Sample_Valid(Sample_Valid),
    .Trig_Level(Trig_Level), .Frame_Start(Frame_Start), .Rd_Addr(Rd_Addr),
    .Rd_Data(Rd_Data), .Start_Offset(Start_Offset), .Trig_Addr(Trig_Addr), .Frozen(Frozen)
  );

  task automatic put(input logic [7:0] v);
    Sample_In = v; Sample_Valid = 1'b1;
    @(posedge Clk); #1;
    Sample_Valid = 1'b0;
  endtask

  task automatic put_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) put(v);
  endtask

  task automatic rd(input logic [11:0] a, output logic [7:0] d);
    Rd_Addr = a;
    @(posedge Clk); #1;
    d = Rd_Data;
  endtask

  task automatic do_reset();
    Sample_Valid = 1'b0; Frame_Start = 1'b0; Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge Clk); #1;
    n_chk++; if (Frozen !== 1'b0) $display("FAIL reset_frozen: got %b want 0", Frozen); else n_pass++;
    n_chk++; if (Trig_Addr !== 12'd0) $display("FAIL reset_trig: got %0d want 0", Trig_Addr); else n_pass++;
    n_chk++; if (Start_Offset !== 12'd0) $display("FAIL reset_start: got %0d want 0", Start_Offset); else n_pass++;
    n_chk++; if (Rd_Data !== 8'd0) $display("FAIL reset_rd: got %0d want 0", Rd_Data); else n_pass++;
    Rst_n = 1'b1;
  endtask

  // Ramp k[7:0] from wr_ptr 0: trigger at 640 (first 127->128 in WAIT_TRIG), last sample index 4223.
  task automatic run_ramp(input string tag);
    logic [7:0] d;
    Trig_Level = 8'd128;
    for (int k = 0; k < 4223; k++) put(8'(k));
    n_chk++; if (Frozen !== 1'b0) $display("FAIL %s_early_frozen: got %b want 0", tag, Frozen); else n_pass++;
    n_chk++; if (Trig_Addr !== 12'd640) $display("FAIL %s_trig: got %0d want 640", tag, Trig_Addr); else n_pass++;
    n_chk++; if (Start_Offset !== 12'd128) $display("FAIL %s_start: got %0d want 128", tag, Start_Offset); else n_pass++;
    put(8'(4223));
    n_chk++; if (Frozen !== 1'b1) $display("FAIL %s_frozen: got %b want 1", tag, Frozen); else n_pass++;
    put_n(8'hAA, 3);
    n_chk++; if (Frozen !== 1'b1) $display("FAIL %s_hold: got %b want 1", tag, Frozen); else n_pass++;
    rd(12'd640, d);
    n_chk++; if (d !== 8'd128) $display("FAIL %s_rd_trig: got %0d want 128", tag, d); else n_pass++;
    rd(12'd128, d);
    n_chk++; if (d !== 8'd128) $display("FAIL %s_rd_nowrite: got %0d want 128", tag, d); else n_pass++;
    rd(12'd127, d);
    n_chk++; if (d !== 8'd127) $display("FAIL %s_rd_last: got %0d want 127", tag, d); else n_pass++;
  endtask

  task automatic test_frame_start();
    logic [7:0] d;
    Sample_In = 8'h55; Sample_Valid = 1'b1; Frame_Start = 1'b1;
    @(posedge Clk); #1;
    Sample_Valid = 1'b0; Frame_Start = 1'b0;
    n_chk++; if (Frozen !== 1'b0) $display("FAIL fs_unfreeze: got %b want 0", Frozen); else n_pass++;
    // Writes resume at 128; 200 at 639 is the 512th fill sample and must be ignored.
    put_n(8'd10, 511); put(8'd200); put(8'd10);
    n_chk++; if (Trig_Addr !== 12'd640) $display("FAIL fs_fill_ignored: got %0d want 640", Trig_Addr); else n_pass++;
    put(8'd200);
    n_chk++; if (Trig_Addr !== 12'd641) $display("FAIL fs_trig: got %0d want 641", Trig_Addr); else n_pass++;
    n_chk++; if (Start_Offset !== 12'd129) $display("FAIL fs_start: got %0d want 129", Start_Offset); else n_pass++;
    put_n(8'd33, 3582);
    n_chk++; if (Frozen !== 1'b0) $display("FAIL fs_early_frozen: got %b want 0", Frozen); else n_pass++;
    put(8'd33);
    n_chk++; if (Frozen !== 1'b1) $display("FAIL fs_frozen: got %b want 1", Frozen); else n_pass++;
    rd(12'd639, d);
    n_chk++; if (d !== 8'd200) $display("FAIL fs_rd639: got %0d want 200", d); else n_pass++;
    rd(12'd640, d);
    n_chk++; if (d !== 8'd10) $display("FAIL fs_rd640: got %0d want 10", d); else n_pass++;
    rd(12'd129, d);
    n_chk++; if (d !== 8'd10) $display("FAIL fs_rd129: got %0d want 10", d); else n_pass++;
  endtask

  task automatic test_fill_cross_and_reset();
    do_reset();
    Trig_Level = 8'd128;
    put_n(8'd10, 50);
    Frame_Start = 1'b1; put(8'd10); Frame_Start = 1'b0;
    put_n(8'd10, 49); put(8'd200); put_n(8'd10, 411);
    n_chk++; if (Trig_Addr !== 12'd0) $display("FAIL fc_fill_ignored: got %0d want 0", Trig_Addr); else n_pass++;
    put_n(8'd10, 8); put(8'd200);
    n_chk++; if (Trig_Addr !== 12'd520) $display("FAIL fc_trig: got %0d want 520", Trig_Addr); else n_pass++;
    n_chk++; if (Start_Offset !== 12'd8) $display("FAIL fc_start: got %0d want 8", Start_Offset); else n_pass++;
    put_n(8'd10, 100);
    #2 Rst_n = 1'b0;
    #1;
    n_chk++; if (Trig_Addr !== 12'd0) $display("FAIL rst_post_trig: got %0d want 0", Trig_Addr); else n_pass++;
    n_chk++; if (Frozen !== 1'b0) $display("FAIL rst_post_frozen: got %b want 0", Frozen); else n_pass++;
    @(posedge Clk); #1 Rst_n = 1'b1;
    run_ramp("fresh");
    #3 Rst_n = 1'b0;
    #1;
    n_chk++; if (Frozen !== 1'b0) $display("FAIL rst_async_frozen: got %b want 0", Frozen); else n_pass++;
    @(posedge Clk); #1 Rst_n = 1'b1;
  endtask

  task automatic test_no_trig();
    do_reset();
    Trig_Level = 8'd100;
    put_n(8'd200, 512 + 16 + 3582);
    n_chk++; if (Frozen !== 1'b0) $display("FAIL nt_early: got %b want 0", Frozen); else n_pass++;
    put(8'd200);
`ifdef ADC_CAP_AUTO_TRIG_EN
    n_chk++; if (Frozen !== 1'b1) $display("FAIL nt_auto_frozen: got %b want 1", Frozen); else n_pass++;
    n_chk++; if (Trig_Addr !== 12'd527) $display("FAIL nt_auto_trig: got %0d want 527", Trig_Addr); else n_pass++;
    n_chk++; if (Start_Offset !== 12'd15) $display("FAIL nt_auto_start: got %0d want 15", Start_Offset); else n_pass++;
`else
    n_chk++; if (Frozen !== 1'b0) $display("FAIL nt_frozen: got %b want 0", Frozen); else n_pass++;
    n_chk++; if (Trig_Addr !== 12'd0) $display("FAIL nt_trig: got %0d want 0", Trig_Addr); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    logic [7:0]  d;
    logic [11:0] a;
    do_reset();
    Trig_Level = 8'd0;
    for (int k = 0; k < 4090; k++) put(8'(k));
    Trig_Level = 8'd250;
    put(8'(4090));
    n_chk++; if (Trig_Addr !== 12'd4090) $display("FAIL wr_trig: got %0d want 4090", Trig_Addr); else n_pass++;
    n_chk++; if (Start_Offset !== 12'd3578) $display("FAIL wr_start: got %0d want 3578", Start_Offset); else n_pass++;
    for (int k = 4091; k < 7674; k++) put(8'(k));
    n_chk++; if (Frozen !== 1'b1) $display("FAIL wr_frozen: got %b want 1", Frozen); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      a = 12'(4092 + i);
      rd(a, d);
      n_chk++; if (d !== a[7:0]) $display("FAIL wr_rd addr %0d: got %0d want %0d", a, d, a[7:0]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    run_ramp("ramp");
    test_frame_start();
    test_fill_cross_and_reset();
    test_no_trig();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
